register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the team's 16x16 two-read/one-write register block. Storage is clocked, with asynchronous clear, write-to-read bypass and an optional hard-wired zero register. A per-register pending scoreboard lets the issue stage reserve a destination register and see, through per-port ready flags, whether a read operand is valid. It sits between the decode/issue stage and the ALU operand muxes of the CPU datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never pending
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all registers and all pending bits
- reg_1  input  ADDR_W  read port 1 address
- reg_2  input  ADDR_W  read port 2 address
- data_1  output  DATA_W  read port 1 data, combinational
- data_2  output  DATA_W  read port 2 data, combinational
- ready_1  output  1  port 1 operand valid, combinational
- ready_2  output  1  port 2 operand valid, combinational
- regWrite  input  1  write enable
- write_addr  input  ADDR_W  write address
- write_data  input  DATA_W  write data
- claim_en  input  1  reserve a destination register (set its pending bit)
- claim_addr  input  ADDR_W  register to reserve
- claim_err  output  1  combinational; claim of an already-pending register not released this cycle
- pending  output  DEPTH  pending bit vector, registered; bit i belongs to register i

## Operation
- Reset (asynchronous): every register is cleared to 0 and `pending` to all zeros.
  - Outputs during reset: data_1 = data_2 = 0, ready_1 = ready_2 = 1, claim_err = 0.
  - The bypass is suppressed while reset is high.
- Write: on a rising edge with regWrite = 1, regs[write_addr] <= write_data.
  - The write is dropped if ZERO_REG = 1 and write_addr = 0.
- Read (port n): the bypass term is regWrite && write_addr == reg_n, excluding the zero register.
  - If the bypass term is true, data_n = write_data.
  - Otherwise data_n = regs[reg_n].
  - data_n = 0 when ZERO_REG = 1 and reg_n = 0.
- Ready (port n): ready_n = !pending[reg_n] || bypass term for port n.
  - ready_n is always 1 for the zero register.
- Scoreboard, per bit i on each rising edge:
  - Set if claim_en && claim_addr == i.
  - Else cleared if regWrite && write_addr == i.
  - Else held.
- Same-cycle claim and write to one address: the claim wins and the bit stays/becomes 1. This models back-to-back producers: the old value retires and the new producer owns the register.
- Write to a non-pending register is legal: data is updated and the bit stays 0.
- Claims of register 0 are ignored when ZERO_REG = 1.
- claim_err = claim_en && pending[claim_addr] && !(regWrite && write_addr == claim_addr).
  - The claim is still accepted; claim_err is advisory only.
- Both read ports may address the same register; they return identical data and ready.

## Timing
- Write latency: 1 edge to storage; 0 cycles to read ports via the bypass.
- Pending set/clear is visible on `pending` and ready_n from the edge after claim/write.
- The ready_n bypass makes ready_n = 1 in the same cycle as the releasing write.
- No internal stalls. Every input is sampled on every edge; no handshake back-pressure.
- Reset asserted mid-operation overrides any write or claim in that cycle, and all state clears immediately (asynchronously).
- Reset deassertion: the first edge with reset = 0 performs normal updates.
- Address wrap: addresses are exactly ADDR_W bits, so there is no out-of-range case.

## Test plan
Defaults used: DATA_W = 16, ADDR_W = 4, ZERO_REG = 1.
- Reset, then read reg_1 = 3, reg_2 = 4 -> data 0x0000/0x0000, ready 1/1, pending = 0x0000.
- regWrite = 1, write_addr = 5, write_data = 0xFFFF, reg_1 = 5, same cycle -> data_1 = 0xFFFF before the edge. Next cycle with regWrite = 0: data_1 = 0xFFFF from storage.
- Write 0xABCD to address 0 -> reg_1 = 0 reads 0x0000 and pending[0] stays 0.
- claim_en = 1, claim_addr = 2, then reg_1 = 2 -> pending = 0x0004, ready_1 = 0.
  - Then write 0x1234 to address 2 -> ready_1 = 1 and data_1 = 0x1234 in the write cycle; pending = 0x0000 after the edge.
- pending[7] = 1; claim 7 and write 7 (0x00AA) in the same cycle -> claim_err = 0, pending[7] = 1 after the edge, regs[7] = 0x00AA.
  - Then a claim of 7 with no write -> claim_err = 1.
- Claim 9 and write 0x5555 to address 9, then assert reset asynchronously mid-cycle -> pending = 0 and data reads 0x0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass and a
// per-register pending scoreboard for operand readiness.
module register_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      reg_1,
  input  logic [ADDR_W-1:0]      reg_2,
  output logic [DATA_W-1:0]      data_1,
  output logic [DATA_W-1:0]      data_2,
  output logic                   ready_1,
  output logic                   ready_2,
  input  logic                   regWrite,
  input  logic [ADDR_W-1:0]      write_addr,
  input  logic [DATA_W-1:0]      write_data,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic                   claim_err,
  output logic [2**ADDR_W-1:0]   pending
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr_ok;
  logic              claim_ok;
  logic              byp_1;
  logic              byp_2;
  logic              zero_1;
  logic              zero_2;

  assign wr_ok    = regWrite &&
                    !(ZERO_REG && write_addr == '0);
  assign claim_ok = claim_en &&
                    !(ZERO_REG && claim_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  // A claim beats a release to the same register: the new producer owns it.
  always_comb begin
    pend_nxt = pending;
    for (int i = 0; i < DEPTH; i++) begin
      if (claim_ok && claim_addr == ADDR_W'(i))
        pend_nxt[i] = 1'b1;
      else if (wr_ok && write_addr == ADDR_W'(i))
        pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= pend_nxt;
  end

  assign zero_1 = ZERO_REG && reg_1 == '0;
  assign zero_2 = ZERO_REG && reg_2 == '0;
  assign byp_1  = !reset && wr_ok && write_addr == reg_1;
  assign byp_2  = !reset && wr_ok && write_addr == reg_2;

  assign data_1 = zero_1 ? '0 :
                  byp_1  ? write_data : regs[reg_1];
  assign data_2 = zero_2 ? '0 :
                  byp_2  ? write_data : regs[reg_2];

  assign ready_1 = zero_1 || byp_1 || !pending[reg_1];
  assign ready_2 = zero_2 || byp_2 || !pending[reg_2];

  assign claim_err = !reset && claim_en &&
                     pending[claim_addr] &&
                     !(regWrite && write_addr == claim_addr);

endmodule

// File: tb/tb_register_file_sb.sv
// Directed vector bench for register_file_sb: bypass, zero register,
// scoreboard claim/release and asynchronous reset.
module tb_register_file_sb;

  logic        clk;
  logic        reset;
  logic [3:0]  reg_1;
  logic [3:0]  reg_2;
  logic [15:0] data_1;
  logic [15:0] data_2;
  logic        ready_1;
  logic        ready_2;
  logic        regWrite;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic        claim_err;
  logic [15:0] pending;

  int checks;
  int failures;

  register_file_sb #(
    .DATA_W(16),
    .ADDR_W(4),
    .ZERO_REG(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_1(reg_1),
    .reg_2(reg_2),
    .data_1(data_1),
    .data_2(data_2),
    .ready_1(ready_1),
    .ready_2(ready_2),
    .regWrite(regWrite),
    .write_addr(write_addr),
    .write_data(write_data),
    .claim_en(claim_en),
    .claim_addr(claim_addr),
    .claim_err(claim_err),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ce;
    logic [3:0]  ca;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rd1;
    logic        rd2;
    logic        cerr;
    logic [15:0] pend;
  } vec_t;

  vec_t v [13];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    regWrite   = 1'b0;
    write_addr = 4'd0;
    write_data = 16'h0;
    claim_en   = 1'b0;
    claim_addr = 4'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    reg_1    = 4'd3;
    reg_2    = 4'd4;
    idle();

    //  r1 r2  we wa wd        ce ca  d1        d2        rd1 rd2 cerr pend
    v[0]  = '{3, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000};
    v[1]  = '{5, 5, 1, 5, 16'hFFFF, 0, 0, 16'hFFFF, 16'hFFFF, 1, 1, 0, 16'h0000};
    v[2]  = '{5, 0, 0, 0, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 1, 1, 0, 16'h0000};
    v[3]  = '{0, 5, 1, 0, 16'hABCD, 0, 0, 16'h0000, 16'hFFFF, 1, 1, 0, 16'h0000};
    v[4]  = '{0, 3, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000};
    v[5]  = '{2, 0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 1, 1, 0, 16'h0004};
    v[6]  = '{2, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0004};
    v[7]  = '{2, 2, 1, 2, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 1, 0, 16'h0000};
    v[8]  = '{7, 5, 0, 0, 16'h0000, 1, 7, 16'h0000, 16'hFFFF, 1, 1, 0, 16'h0080};
    v[9]  = '{7, 7, 1, 7, 16'h00AA, 1, 7, 16'h00AA, 16'h00AA, 1, 1, 0, 16'h0080};
    v[10] = '{7, 2, 0, 0, 16'h0000, 1, 7, 16'h00AA, 16'h1234, 0, 1, 1, 16'h0080};
    v[11] = '{9, 7, 1, 9, 16'h5555, 1, 9, 16'h5555, 16'h00AA, 1, 0, 0, 16'h0280};
    v[12] = '{9, 3, 1, 3, 16'h0033, 1, 3, 16'h5555, 16'h0033, 0, 1, 0, 16'h0288};

    #2;
    chk("rst_data_1", 32'(data_1), 32'h0);
    chk("rst_data_2", 32'(data_2), 32'h0);
    chk("rst_ready", {ready_1, ready_2}, 32'h3);
    chk("rst_claim_err", 32'(claim_err), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reg_1      = v[i].r1;
      reg_2      = v[i].r2;
      regWrite   = v[i].we;
      write_addr = v[i].wa;
      write_data = v[i].wd;
      claim_en   = v[i].ce;
      claim_addr = v[i].ca;
      #1;
      chk($sformatf("v%0d_data_1", i), 32'(data_1), 32'(v[i].d1));
      chk($sformatf("v%0d_data_2", i), 32'(data_2), 32'(v[i].d2));
      chk($sformatf("v%0d_ready_1", i), 32'(ready_1), 32'(v[i].rd1));
      chk($sformatf("v%0d_ready_2", i), 32'(ready_2), 32'(v[i].rd2));
      chk($sformatf("v%0d_claim_err", i), 32'(claim_err), 32'(v[i].cerr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(v[i].pend));
    end

    // Asynchronous reset mid-cycle while a claim and write are in flight.
    @(negedge clk);
    reg_1      = 4'd9;
    reg_2      = 4'd3;
    regWrite   = 1'b1;
    write_addr = 4'd9;
    write_data = 16'h5555;
    claim_en   = 1'b1;
    claim_addr = 4'd9;
    #1;
    chk("pre_rst_bypass", 32'(data_1), 32'h5555);
    chk("pre_rst_data_2", 32'(data_2), 32'h0033);
    #1;
    reset = 1'b1;
    #1;
    chk("async_pending", 32'(pending), 32'h0);
    chk("async_data_1", 32'(data_1), 32'h0);
    chk("async_data_2", 32'(data_2), 32'h0);
    chk("async_ready", {ready_1, ready_2}, 32'h3);
    chk("async_claim_err", 32'(claim_err), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_edge_pending", 32'(pending), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    idle();
    reg_1 = 4'd9;
    reg_2 = 4'd7;
    #1;
    chk("post_rst_r9", 32'(data_1), 32'h0);
    chk("post_rst_r7", 32'(data_2), 32'h0);

    // First edge after reset performs a normal update.
    regWrite   = 1'b1;
    write_addr = 4'd4;
    write_data = 16'h4444;
    claim_en   = 1'b1;
    claim_addr = 4'd4;
    @(posedge clk);
    #1;
    chk("first_edge_pending", 32'(pending), 32'h0010);
    @(negedge clk);
    idle();
    reg_1 = 4'd4;
    #1;
    chk("first_edge_data", 32'(data_1), 32'h4444);
    chk("first_edge_ready", 32'(ready_1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
